// File: rtl/spu_pkg.sv
// Shared front-end types and constants for the dual-issue SPU.
package spu_pkg;

    localparam int unsigned WORD = 32;

    // Encoding driven on an empty issue slot.
    localparam logic [WORD-1:0] LNOP = 32'h0020_0000;

    typedef enum logic [1:0] {
        StRun,
        StRedirect,
        StHalt
    } fetch_state_t;

    typedef struct packed {
        logic [WORD-1:0] instr;
        logic [WORD-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_fifo.sv
// Circular instruction queue: up to two pushes and two pops per cycle, flushable.
// The caller guarantees pushes never exceed the free slots left after this cycle's pops.
module iq_fifo
    import spu_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [1:0]                 push_i,
    input  iq_entry_t                  push0_i,
    input  iq_entry_t                  push1_i,
    input  logic [1:0]                 pop_i,
    output logic [$clog2(Depth):0]     count_o,
    output iq_entry_t                  head0_o,
    output iq_entry_t                  head1_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    iq_entry_t       mem_q [Depth];
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PtrW'(pop_i);
            tail_q  <= tail_q + PtrW'(push_i);
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage needs no reset; only slots below count are ever presented as valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i) begin
            if (push_i != 2'd0) mem_q[tail_q] <= push0_i;
            if (push_i == 2'd2) mem_q[tail_q + 1'b1] <= push1_i;
        end
    end

    // Expose the two oldest entries.
    always_comb begin
        head0_o = mem_q[head_q];
        head1_o = mem_q[head_q + 1'b1];
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Dual-issue front end: owns the fetch PC, fills the instruction queue from IMEM,
// presents the two oldest instructions to issue, and handles redirect and halt.
// Codebase bit numbering is MSB-0; here vectors are [N-1:0], so codebase bit 29 of
// an address is bit 2 and codebase fetch_data bits 0..WORD-1 are the upper half.
module fetch_queue_ctrl
    import spu_pkg::*;
#(
    parameter int unsigned Depth     = 8,
    parameter int unsigned ImemBytes = 2048
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              stop_and_signal_i,
    input  logic              branch_taken_i,
    input  logic [WORD-1:0]   bta_i,
    output logic [WORD-1:0]   fetch_pc_o,
    output logic              fetch_two_o,
    output logic              fetch_en_o,
    input  logic [2*WORD-1:0] fetch_data_i,
    output logic [WORD-1:0]   instr1_o,
    output logic [WORD-1:0]   instr2_o,
    output logic [WORD-1:0]   instr1_pc_o,
    output logic              valid1_o,
    output logic              valid2_o,
    input  logic [1:0]        consume_i,
    output logic              halted_o
);

    localparam int unsigned   CntW     = $clog2(Depth) + 1;
    localparam logic [WORD-1:0] ImemSize = WORD'(ImemBytes);

    fetch_state_t    state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;

    logic [CntW-1:0] count, cons_req, cons_eff, post_cnt, free_slots, need;
    logic [WORD-1:0] pc_inc, pc_next, bta_target;
    logic            fetch_two, fetch_go, flush, cons_applied;
    logic [1:0]      push, pop;
    iq_entry_t       push0, push1, head0, head1;
    logic            unused_head1_pc;

    assign unused_head1_pc = ^head1.pc;

    // An odd-word PC fetches a single word so the following fetch is 8-byte aligned.
    assign fetch_two  = !pc_q[2];
    assign need       = fetch_two ? CntW'(2) : CntW'(1);
    assign pc_inc     = pc_q + (fetch_two ? WORD'(8) : WORD'(4));
    assign pc_next    = (pc_inc >= ImemSize) ? pc_inc - ImemSize : pc_inc;
    assign bta_target = (bta_i & ~WORD'(3)) % ImemSize;

    // Issue acceptance is clipped to what the queue actually holds.
    assign cons_req   = (consume_i > 2'd2) ? CntW'(2) : CntW'(consume_i);
    assign cons_eff   = (cons_req > count) ? count : cons_req;
    assign post_cnt   = count - cons_eff;
    assign free_slots = CntW'(Depth) - post_cnt;

    // Next-state: branch flushes unless stop arrives in the same cycle; HALT only drains.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush        = 1'b0;
        push         = 2'd0;
        fetch_go     = 1'b0;
        cons_applied = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                StRun, StRedirect: begin
                    if (stop_and_signal_i) begin
                        state_d      = StHalt;
                        cons_applied = 1'b1;
                    end else if (branch_taken_i) begin
                        flush   = 1'b1;
                        pc_d    = bta_target;
                        state_d = StRedirect;
                    end else begin
                        cons_applied = 1'b1;
                        if (state_q == StRedirect) begin
                            state_d = StRun;
                        end else if (free_slots >= need) begin
                            fetch_go = 1'b1;
                            push     = fetch_two ? 2'd2 : 2'd1;
                            pc_d     = pc_next;
                        end
                    end
                end
                StHalt: cons_applied = 1'b1;
                default: state_d = StRun;
            endcase
        end
        pop = cons_applied ? 2'(cons_eff) : 2'd0;
    end

    // State and fetch PC registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StRun;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Pair each fetched word with its byte address.
    always_comb begin
        push0.instr = fetch_data_i[2*WORD-1:WORD];
        push0.pc    = pc_q;
        push1.instr = fetch_data_i[WORD-1:0];
        push1.pc    = pc_q + WORD'(4);
    end

    iq_fifo #(
        .Depth (Depth)
    ) u_iq_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush),
        .push_i  (push),
        .push0_i (push0),
        .push1_i (push1),
        .pop_i   (pop),
        .count_o (count),
        .head0_o (head0),
        .head1_o (head1)
    );

    // Issue-facing outputs; empty slots carry LNOP.
    always_comb begin
        valid1_o    = !reset_i && (state_q != StRedirect) && (count >= CntW'(1));
        valid2_o    = !reset_i && (state_q != StRedirect) && (count >= CntW'(2));
        instr1_o    = valid1_o ? head0.instr : LNOP;
        instr2_o    = valid2_o ? head1.instr : LNOP;
        instr1_pc_o = head0.pc;
        fetch_pc_o  = pc_q;
        fetch_two_o = fetch_two;
        fetch_en_o  = fetch_go;
        halted_o    = (state_q == StHalt);
    end

    // Issue must never accept more than is queued.
    assert property (@(posedge clk_i) disable iff (reset_i)
        cons_applied |-> (consume_i <= 2'd2 && CntW'(consume_i) <= count))
        else $error("consume exceeds queued count");

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl with a queue-level reference model.
module tb_fetch_queue_ctrl;

    localparam int DEPTH = 8;
    localparam int IMEM  = 2048;
    localparam logic [31:0] NOP = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        reset, stop, br;
    logic [31:0] bta;
    logic [31:0] fetch_pc, instr1, instr2, instr1_pc;
    logic        fetch_two, fetch_en, valid1, valid2, halted;
    logic [63:0] fetch_data;
    logic [1:0]  consume;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] q_ins[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    int          m_state; // 0 = running, 1 = redirect bubble, 2 = halted

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b0;
    bit          e_rst;
    logic [31:0] e_fetch_pc, e_instr1, e_instr2, e_pc1;
    logic        e_fetch_two, e_fetch_en, e_valid1, e_valid2, e_halted;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    // Combinational IMEM driven from the address the DUT presents.
    assign fetch_data = {mem_word(fetch_pc), mem_word(fetch_pc + 32'd4)};

    fetch_queue_ctrl #(
        .Depth     (DEPTH),
        .ImemBytes (IMEM)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .stop_and_signal_i (stop),
        .branch_taken_i    (br),
        .bta_i             (bta),
        .fetch_pc_o        (fetch_pc),
        .fetch_two_o       (fetch_two),
        .fetch_en_o        (fetch_en),
        .fetch_data_i      (fetch_data),
        .instr1_o          (instr1),
        .instr2_o          (instr2),
        .instr1_pc_o       (instr1_pc),
        .valid1_o          (valid1),
        .valid2_o          (valid2),
        .consume_i         (consume),
        .halted_o          (halted)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("fetch_en", {31'd0, fetch_en}, {31'd0, e_fetch_en});
            cmp("valid1", {31'd0, valid1}, {31'd0, e_valid1});
            cmp("valid2", {31'd0, valid2}, {31'd0, e_valid2});
            if (!e_rst) begin
                cmp("fetch_pc", fetch_pc, e_fetch_pc);
                cmp("fetch_two", {31'd0, fetch_two}, {31'd0, e_fetch_two});
                cmp("halted", {31'd0, halted}, {31'd0, e_halted});
                cmp("instr1", instr1, e_instr1);
                cmp("instr2", instr2, e_instr2);
                if (e_valid1) cmp("instr1_pc", instr1_pc, e_pc1);
            end
        end
    end

    // One clock: drive inputs after the edge, derive expectations, advance the model.
    task automatic step(input bit rst, input int cons, input bit brn,
                        input logic [31:0] tgt, input bit stp);
        int n, eff, need;
        @(posedge clk);
        #1;
        n   = q_ins.size();
        eff = (cons > n) ? n : cons;
        reset   = rst;
        consume = 2'(eff);
        br      = brn;
        bta     = tgt;
        stop    = stp;
        e_rst   = rst;
        if (rst) begin
            e_fetch_en = 1'b0;
            e_valid1   = 1'b0;
            e_valid2   = 1'b0;
            q_ins.delete();
            q_pc.delete();
            m_pc    = 32'd0;
            m_state = 0;
        end else begin
            need        = (m_pc % 8 == 0) ? 2 : 1;
            e_fetch_pc  = m_pc;
            e_fetch_two = (need == 2);
            e_halted    = (m_state == 2);
            e_valid1    = (m_state != 1) && (n >= 1);
            e_valid2    = (m_state != 1) && (n >= 2);
            e_instr1    = NOP;
            e_instr2    = NOP;
            e_pc1       = 32'd0;
            if (e_valid1) begin
                e_instr1 = q_ins[0];
                e_pc1    = q_pc[0];
            end
            if (e_valid2) e_instr2 = q_ins[1];
            e_fetch_en = (m_state == 0) && !stp && !brn && (DEPTH - (n - eff) >= need);
            if (m_state == 2 || stp) begin
                for (int k = 0; k < eff; k++) begin
                    void'(q_ins.pop_front());
                    void'(q_pc.pop_front());
                end
                m_state = 2;
            end else if (brn) begin
                q_ins.delete();
                q_pc.delete();
                m_pc    = (tgt & ~32'd3) % IMEM;
                m_state = 1;
            end else begin
                for (int k = 0; k < eff; k++) begin
                    void'(q_ins.pop_front());
                    void'(q_pc.pop_front());
                end
                if (m_state == 1) begin
                    m_state = 0;
                end else if (e_fetch_en) begin
                    for (int k = 0; k < need; k++) begin
                        q_ins.push_back(mem_word(m_pc + 32'(4 * k)));
                        q_pc.push_back(m_pc + 32'(4 * k));
                    end
                    m_pc = (m_pc + 32'(4 * need)) % IMEM;
                end
            end
        end
        chk_en = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; stop = 1'b0; br = 1'b0; bta = '0; consume = '0;
        m_pc = '0; m_state = 0;

        // Streaming with full consumption: pairs 1/2, 3/4, ... at PCs 0, 8, 16, ...
        step(1, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        cmp("lit_first_pc", fetch_pc, 32'd0);
        cmp("lit_first_valid1", {31'd0, valid1}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            step(0, 2, 0, 0, 0);
            cmp("lit_stream_i1", instr1, 32'(2 * i - 1));
            cmp("lit_stream_i2", instr2, 32'(2 * i));
            cmp("lit_stream_pc", fetch_pc, 32'(8 * i));
        end

        // Fill without consumption, then partial consumption.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            if (i >= 4) begin
                cmp("lit_full_fetch_en", {31'd0, fetch_en}, 32'd0);
                cmp("lit_full_pc", fetch_pc, 32'd32);
            end
        end
        step(0, 1, 0, 0, 0);
        cmp("lit_one_free_no_fetch", {31'd0, fetch_en}, 32'd0);
        step(0, 1, 0, 0, 0);
        cmp("lit_shift_instr1", instr1, 32'd2);
        cmp("lit_two_free_fetch", {31'd0, fetch_en}, 32'd1);
        step(0, 0, 0, 0, 0);
        cmp("lit_shift_instr1_b", instr1, 32'd3);

        // Branch to 0x14 with 6 words queued.
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h14, 0);
        step(0, 0, 0, 0, 0);
        cmp("lit_redirect_valid1", {31'd0, valid1}, 32'd0);
        cmp("lit_redirect_valid2", {31'd0, valid2}, 32'd0);
        step(0, 0, 0, 0, 0);
        cmp("lit_bta_pc", fetch_pc, 32'h14);
        cmp("lit_bta_single", {31'd0, fetch_two}, 32'd0);
        step(0, 0, 0, 0, 0);
        cmp("lit_bta_pc2", fetch_pc, 32'h18);
        cmp("lit_bta_double", {31'd0, fetch_two}, 32'd1);
        cmp("lit_bta_instr1_pc", instr1_pc, 32'h14);
        cmp("lit_bta_instr1", instr1, 32'd6);

        // Misaligned target together with consume = 2.
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 2, 1, 32'h17, 0);
        step(0, 0, 0, 0, 0);
        cmp("lit_misalign_valid1", {31'd0, valid1}, 32'd0);
        step(0, 0, 0, 0, 0);
        cmp("lit_misalign_pc", fetch_pc, 32'h14);

        // Stop and branch together: stop wins, queue kept.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h40, 1);
        step(0, 0, 0, 0, 0);
        cmp("lit_sb_halted", {31'd0, halted}, 32'd1);
        cmp("lit_sb_instr1", instr1, 32'd1);
        cmp("lit_sb_pc", fetch_pc, 32'd8);

        // Stop with 4 queued words, drain one per cycle, branch ignored.
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        cmp("lit_stop_fetch_en", {31'd0, fetch_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            cmp("lit_drain_halted", {31'd0, halted}, 32'd1);
            cmp("lit_drain_instr1", instr1, 32'(i + 2));
        end
        step(0, 1, 0, 0, 0);
        cmp("lit_drained_valid1", {31'd0, valid1}, 32'd0);
        cmp("lit_drained_lnop", instr1, NOP);
        step(0, 0, 1, 32'h40, 0);
        step(0, 0, 0, 0, 0);
        cmp("lit_halt_branch_pc", fetch_pc, 32'd16);
        cmp("lit_halt_sticky", {31'd0, halted}, 32'd1);

        // Reset mid-run with a full queue.
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        cmp("lit_rst_fetch_en", {31'd0, fetch_en}, 32'd0);
        step(0, 0, 0, 0, 0);
        cmp("lit_rst_valid1", {31'd0, valid1}, 32'd0);
        cmp("lit_rst_pc", fetch_pc, 32'd0);
        cmp("lit_rst_halted", {31'd0, halted}, 32'd0);
        cmp("lit_rst_refetch", {31'd0, fetch_en}, 32'd1);
        step(0, 0, 0, 0, 0);
        cmp("lit_rst_instr1", instr1, 32'd1);
        cmp("lit_rst_instr1_pc", instr1_pc, 32'd0);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
